// File: rtl/seq_mult_pkg.sv
// ============================================================================
// Module : seq_mult_pkg
// Brief  : Shared types and helpers for the sequential shift-add multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam state_t STATE_RESET = ST_IDLE;

    // Bits needed to hold values 0..n-1 (minimum 1).
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/twos_negate.sv
// ============================================================================
// Module : twos_negate
// Brief  : Combinational conditional two's-complement negation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module twos_negate #(
    parameter int WIDTH = 4
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    logic [WIDTH-1:0] w_one;

    assign w_one = {{(WIDTH-1){1'b0}}, 1'b1};
    assign o_val = i_neg ? ((~i_val) + w_one) : i_val;

endmodule

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module : seq_multiplier
// Brief  : Sequential shift-add multiplier, signed/unsigned, start/busy/done.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p,
    output logic               busy,
    output logic               done
);

    localparam int               CNT_W  = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_last;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mlier;
    logic [2*WIDTH:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_p;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_addend;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH:0]     w_acc_nxt;
    logic [2*WIDTH-1:0]   w_p_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STATE_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = STATE_RESET;
        endcase
    end

    // Operands are stored as magnitudes; the sign is reapplied to the product.
    twos_negate #(.WIDTH(WIDTH)) u_neg_a (
        .i_neg (signed_mode & a[WIDTH-1]),
        .i_val (a),
        .o_val (w_a_mag)
    );

    twos_negate #(.WIDTH(WIDTH)) u_neg_b (
        .i_neg (signed_mode & b[WIDTH-1]),
        .i_val (b),
        .o_val (w_b_mag)
    );

    assign w_addend  = r_mlier[0] ? {1'b0, r_mcand} : '0;
    assign w_sum     = r_acc[2*WIDTH:WIDTH] + w_addend;
    assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:0]} >> 1;

    // Sign correction works on the final iteration's result so p lands on that edge.
    twos_negate #(.WIDTH(2*WIDTH)) u_neg_p (
        .i_neg (r_neg),
        .i_val (w_acc_nxt[2*WIDTH-1:0]),
        .o_val (w_p_fix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= '0;
            r_mlier <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_p     <= '0;
        end else if (w_accept) begin
            r_mcand <= w_a_mag;
            r_mlier <= w_b_mag;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (r_state == ST_RUN) begin
            r_acc   <= w_acc_nxt;
            r_mlier <= r_mlier >> 1;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_p <= w_p_fix;
            end
        end
    end

    assign p = r_p;

endmodule

`default_nettype wire
